ysyx_idu_issue: RTL and testbench
=================================

Name: ysyx_idu_issue

Overview:
Decode-and-issue stage directly downstream of the instruction fetch unit in the ysyx RV32I core. It accepts {inst, pc} over a valid/ready handshake and decodes the RV32I fields and immediate. A per-register busy scoreboard blocks read-after-write and write-after-write hazards. The decoded packet is held in a one-entry output register toward the execute unit, and the stage is flushed on bad branch speculation.

Parameters:
DATA_W, 32, data/address width
NREG, 32, architectural register count (x0 hardwired, never busy)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
inst_i  input  DATA_W  instruction from fetch
pc_i  input  DATA_W  pc of inst_i
prev_valid  input  1  fetch packet valid
ready_o  output  1  stage can accept this cycle
flush_i  input  1  bad-speculation kill, pulse
wb_valid_i  input  1  writeback retire pulse
wb_rd_i  input  5  writeback destination register
next_ready  input  1  execute unit accepts packet
valid_o  output  1  output packet valid
pc_o  output  DATA_W  registered pc
inst_o  output  DATA_W  registered raw instruction
opcode_o  output  7  inst[6:0]
funct3_o  output  3  inst[14:12]
funct7_o  output  7  inst[31:25]
rd_o  output  5  destination register, forced to 0 for S/B types
rs1_o  output  5  source 1 index
rs2_o  output  5  source 2 index
imm_o  output  DATA_W  sign-extended immediate
wen_o  output  1  instruction writes rd (rd != 0 and type in R/I/U/J/load/jalr)
illegal_o  output  1  opcode not in RV32I set (including fence/system)

Behaviour:
- Reset (async, any cycle, including mid-stall): valid_o=0, busy[*]=0, all packet fields 0, ready_o=1 on the first cycle after deassert. No pending state survives reset.
- Combinational decode of inst_i. Immediate formats follow RV32I:
  - I: inst[31:20] sign-extended (loads, op-imm, jalr).
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R type and illegal opcodes: imm = 0.
- Source-use flags:
  - uses_rs1: all types except U and J.
  - uses_rs2: R, S, B only.
- Hazard: (uses_rs1 and busy[rs1]) or (uses_rs2 and busy[rs2]) or (wen and busy[rd]).
  - Evaluated on the registered busy vector only. A writeback in the same cycle does not bypass, so a dependent instruction stalls at least one cycle after the wb pulse is seen.
- Output register free: out_free = !valid_o | next_ready.
- ready_o = out_free and !hazard and !flush_i.
- Issue condition: prev_valid and ready_o. On issue, at the next edge:
  - The packet register loads the decode result and valid_o=1.
  - If wen, busy[rd] is set.
- No issue and next_ready=1 and valid_o=1: valid_o clears at the next edge.
- Output stall: valid_o=1 and next_ready=0 holds every packet field stable (no change while stalled).
- Latency: one cycle from accepted input to valid_o. Sustained throughput is one instruction per cycle when there are no hazards.
- Scoreboard update:
  - wb_valid_i clears busy[wb_rd_i].
  - busy[0] is never set.
  - If set and clear target the same register in the same cycle, set wins. This cannot occur legally because of the WAW stall; the verification engineer asserts it never fires.
- flush_i:
  - At the next edge valid_o=0 and the current input is not accepted (ready_o=0 that cycle).
  - busy bits are unaffected. Every issued instruction, including killed-speculative ones, produces exactly one wb_valid_i pulse, committed or suppressed by the execute unit.
  - flush_i and issue in the same cycle: flush wins and nothing is issued.
  - flush_i with next_ready=0: the packet is dropped.
- Illegal opcode: packet issues normally with illegal_o=1, wen_o=0, and no busy set. Trap handling is downstream.
- No internal FSM beyond the valid bit. Per-cycle state: {valid_o, packet, busy[NREG-1:1]}.

Test Plan:
- Decode / WAW: inst 0x00500093 (addi x1,x0,5) at pc 0x80000000, next_ready=1 -> one cycle later valid_o=1, rd_o=1, rs1_o=0, imm_o=0x00000005, wen_o=1, busy[1]=1. A second addi to x1 next cycle -> ready_o=0 (WAW).
- RAW stall: after the addi, present 0x00108133 (add x2,x1,x1) -> ready_o=0 until the cycle after wb_valid_i=1, wb_rd_i=1. Then it issues with rs1_o=rs2_o=1, rd_o=2, imm_o=0.
- B-immediate: 0xFE000CE3 (beq x0,x0,-8) -> imm_o=0xFFFFFFF8, rd_o=0, wen_o=0, no busy set.
- U/J immediates: 0x123450B7 (lui x1) -> imm_o=0x12345000, uses no sources. 0x008000EF (jal x1,8) -> imm_o=0x00000008.
- Backpressure: issue an addi, hold next_ready=0 for 3 cycles -> valid_o=1 and pc_o/imm_o unchanged, ready_o=0. Release -> the next packet loads in the same edge (back-to-back).
- Flush and reset:
  - Flush with valid_o=1, next_ready=0, prev_valid=1 -> valid_o=0 next cycle, input not consumed, busy unchanged.
  - Assert rst mid-stall with busy[1]=1 -> valid_o=0 and busy all 0 immediately.

Source files
------------

// File: rtl/ysyx_idu_issue.sv
// ysyx_idu_issue: RV32I decode-and-issue stage sitting between fetch and execute.
//
// Accepts {inst, pc} from fetch on a valid/ready handshake, decodes fields and the
// sign-extended immediate, checks a per-register busy scoreboard for RAW/WAW hazards
// and issues into a one-entry output register toward execute.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_i, pc_i, prev_valid      fetch packet and its valid
//   ready_o                       stage accepts the fetch packet this cycle
//   flush_i                       bad-speculation kill (drops the output packet)
//   wb_valid_i, wb_rd_i           writeback retire pulse, clears busy[wb_rd_i]
//   next_ready                    execute accepts the output packet
//   valid_o .. illegal_o          registered decoded packet

module ysyx_idu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              next_ready,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              wen_o,
  output logic              illegal_o
);

  // RV32I major opcodes; fence and system are deliberately absent and decode as illegal.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [31:0]       ins;
  logic [6:0]        dec_opcode;
  logic [4:0]        dec_rs1;
  logic [4:0]        dec_rs2;
  logic [4:0]        dec_rd;
  logic [31:0]       dec_imm32;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic              dec_writes;
  logic              dec_no_rd;
  logic              dec_illegal;
  logic              dec_wen;

  assign ins        = inst_i[31:0];
  assign dec_opcode = ins[6:0];
  assign dec_rs1    = ins[19:15];
  assign dec_rs2    = ins[24:20];

  always_comb begin
    dec_imm32    = '0;
    dec_uses_rs1 = 1'b0;
    dec_uses_rs2 = 1'b0;
    dec_writes   = 1'b0;
    dec_no_rd    = 1'b0;
    dec_illegal  = 1'b0;
    case (dec_opcode)
      OpReg: begin
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        dec_writes   = 1'b1;
      end
      OpLoad, OpImm, OpJalr: begin
        dec_imm32    = {{20{ins[31]}}, ins[31:20]};
        dec_uses_rs1 = 1'b1;
        dec_writes   = 1'b1;
      end
      OpStore: begin
        dec_imm32    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        dec_no_rd    = 1'b1;
      end
      OpBranch: begin
        dec_imm32    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        dec_no_rd    = 1'b1;
      end
      OpLui, OpAuipc: begin
        dec_imm32  = {ins[31:12], 12'b0};
        dec_writes = 1'b1;
      end
      OpJal: begin
        dec_imm32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        dec_writes = 1'b1;
      end
      default: begin
        // Illegal opcodes carry no sources, no immediate and no destination write.
        dec_illegal = 1'b1;
      end
    endcase
  end

  // S/B formats reuse inst[11:7] for immediate bits, so rd reads as x0 there.
  assign dec_rd  = dec_no_rd ? 5'd0 : ins[11:7];
  assign dec_wen = dec_writes && (dec_rd != 5'd0);
  assign dec_imm = DATA_W'($signed(dec_imm32));

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            hazard;
  logic            out_free;
  logic            issue;

  // Only the registered busy vector is consulted; a writeback this cycle does not
  // bypass, so a dependent instruction waits one cycle after the wb pulse.
  assign hazard   = (dec_uses_rs1 && busy_q[dec_rs1])
                 || (dec_uses_rs2 && busy_q[dec_rs2])
                 || (dec_wen      && busy_q[dec_rd]);
  assign out_free = !valid_q || next_ready;
  assign ready_o  = out_free && !hazard && !flush_i;
  assign issue    = prev_valid && ready_o;

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    // Set is applied after clear so it wins on a same-register collision.
    if (issue && dec_wen) begin
      busy_d[dec_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Output packet register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [6:0]        funct7_q, funct7_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              wen_q, wen_d;
  logic              illegal_q, illegal_d;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    wen_d     = wen_q;
    illegal_d = illegal_q;
    if (issue) begin
      valid_d   = 1'b1;
      pc_d      = pc_i;
      inst_d    = inst_i;
      opcode_d  = dec_opcode;
      funct3_d  = ins[14:12];
      funct7_d  = ins[31:25];
      rd_d      = dec_rd;
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
      imm_d     = dec_imm;
      wen_d     = dec_wen;
      illegal_d = dec_illegal;
    end else if (flush_i || next_ready) begin
      // Flush drops the packet even when execute is stalling it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      busy_q    <= '0;
      pc_q      <= '0;
      inst_q    <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      wen_q     <= wen_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign inst_o    = inst_q;
  assign opcode_o  = opcode_q;
  assign funct3_o  = funct3_q;
  assign funct7_o  = funct7_q;
  assign rd_o      = rd_q;
  assign rs1_o     = rs1_q;
  assign rs2_o     = rs2_q;
  assign imm_o     = imm_q;
  assign wen_o     = wen_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ysyx_idu_issue.sv
// Self-checking bench for ysyx_idu_issue: directed scenarios followed by random traffic,
// all compared against a behavioural model (arithmetic immediate construction, a busy
// array and a single expected output packet).

module tb_ysyx_idu_issue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        wen;
    logic        illegal;
    logic        use1;
    logic        use2;
  } pkt_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        prev_valid;
  logic        ready_o;
  logic        flush_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        next_ready;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [31:0] imm_o;
  logic        wen_o;
  logic        illegal_o;

  ysyx_idu_issue #(
    .DATA_W(32),
    .NREG  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_i    (inst_i),
    .pc_i      (pc_i),
    .prev_valid(prev_valid),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .wb_valid_i(wb_valid_i),
    .wb_rd_i   (wb_rd_i),
    .next_ready(next_ready),
    .valid_o   (valid_o),
    .pc_o      (pc_o),
    .inst_o    (inst_o),
    .opcode_o  (opcode_o),
    .funct3_o  (funct3_o),
    .funct7_o  (funct7_o),
    .rd_o      (rd_o),
    .rs1_o     (rs1_o),
    .rs2_o     (rs2_o),
    .imm_o     (imm_o),
    .wen_o     (wen_o),
    .illegal_o (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic obs_rdy;

  // Reference model state.
  bit [31:0] m_busy;
  logic      m_valid;
  pkt_t      m_pkt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t ref_decode(input logic [31:0] x, input logic [31:0] pc);
    pkt_t        p;
    logic [31:0] sx;
    logic        r_t, i_t, s_t, b_t, u_t, j_t;
    p        = '0;
    sx       = {32{x[31]}};
    p.pc     = pc;
    p.inst   = x;
    p.opcode = x[6:0];
    p.funct3 = x[14:12];
    p.funct7 = x[31:25];
    p.rs1    = x[19:15];
    p.rs2    = x[24:20];
    p.rd     = x[11:7];
    r_t = (x[6:0] == 7'h33);
    i_t = (x[6:0] == 7'h03) || (x[6:0] == 7'h13) || (x[6:0] == 7'h67);
    s_t = (x[6:0] == 7'h23);
    b_t = (x[6:0] == 7'h63);
    u_t = (x[6:0] == 7'h37) || (x[6:0] == 7'h17);
    j_t = (x[6:0] == 7'h6f);
    if (i_t) p.imm = (sx << 12) | 32'(x[31:20]);
    if (s_t) p.imm = (sx << 12) | (32'(x[31:25]) << 5) | 32'(x[11:7]);
    if (b_t) p.imm = (sx << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5)
                   | (32'(x[11:8]) << 1);
    if (u_t) p.imm = x & 32'hFFFF_F000;
    if (j_t) p.imm = (sx << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11)
                   | (32'(x[30:21]) << 1);
    if (s_t || b_t) p.rd = 5'd0;
    p.use1    = r_t || i_t || s_t || b_t;
    p.use2    = r_t || s_t || b_t;
    p.illegal = !(r_t || i_t || s_t || b_t || u_t || j_t);
    p.wen     = (r_t || i_t || u_t || j_t) && (p.rd != 5'd0);
    return p;
  endfunction

  task automatic model_reset();
    m_busy  = '0;
    m_valid = 1'b0;
    m_pkt   = '0;
  endtask

  task automatic check_outputs();
    check("valid_o", valid_o, m_valid);
    check("pc_o", pc_o, m_pkt.pc);
    check("inst_o", inst_o, m_pkt.inst);
    check("opcode_o", opcode_o, m_pkt.opcode);
    check("funct3_o", funct3_o, m_pkt.funct3);
    check("funct7_o", funct7_o, m_pkt.funct7);
    check("rd_o", rd_o, m_pkt.rd);
    check("rs1_o", rs1_o, m_pkt.rs1);
    check("rs2_o", rs2_o, m_pkt.rs2);
    check("imm_o", imm_o, m_pkt.imm);
    check("wen_o", wen_o, m_pkt.wen);
    check("illegal_o", illegal_o, m_pkt.illegal);
  endtask

  // Entered and left at posedge+1: drive, check ready, clock, update model, check packet.
  task automatic cycle(input logic [31:0] inst, input logic [31:0] pc, input logic pv,
                       input logic nr, input logic fl, input logic wbv,
                       input logic [4:0] wbrd);
    pkt_t d;
    logic hz, exp_rdy;
    inst_i     = inst;
    pc_i       = pc;
    prev_valid = pv;
    next_ready = nr;
    flush_i    = fl;
    wb_valid_i = wbv;
    wb_rd_i    = wbrd;
    #1;
    d  = ref_decode(inst, pc);
    hz = (d.use1 && m_busy[d.rs1]) || (d.use2 && m_busy[d.rs2]) || (d.wen && m_busy[d.rd]);
    exp_rdy = (!m_valid || nr) && !hz && !fl;
    obs_rdy = ready_o;
    check("ready_o", ready_o, exp_rdy);
    @(posedge clk);
    if (wbv) m_busy[wbrd] = 1'b0;
    if (pv && exp_rdy) begin
      m_valid = 1'b1;
      m_pkt   = d;
      if (d.wen) m_busy[d.rd] = 1'b1;
    end else if (fl || nr) begin
      m_valid = 1'b0;
    end
    m_busy[0] = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    logic [31:0] rinst;
    logic [6:0]  ops [9];
    logic [4:0]  r;
    logic        rwb;
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    rst = 1'b1; inst_i = '0; pc_i = '0; prev_valid = 1'b0; flush_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = '0; next_ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Decode and WAW.
    cycle(32'h00500093, 32'h8000_0000, 1, 1, 0, 0, 0);
    check("first_ready", obs_rdy, 1);
    check("addi_valid", valid_o, 1);
    check("addi_rd", rd_o, 1);
    check("addi_rs1", rs1_o, 0);
    check("addi_imm", imm_o, 32'h5);
    check("addi_wen", wen_o, 1);
    cycle(32'h00500093, 32'h8000_0004, 1, 1, 0, 0, 0);
    check("waw_ready", obs_rdy, 0);

    // RAW stall, no writeback bypass.
    cycle(32'h00108133, 32'h8000_0008, 1, 1, 0, 0, 0);
    check("raw_ready", obs_rdy, 0);
    cycle(32'h00108133, 32'h8000_0008, 1, 1, 0, 1, 5'd1);
    check("raw_wb_same_cycle", obs_rdy, 0);
    cycle(32'h00108133, 32'h8000_0008, 1, 1, 0, 0, 0);
    check("raw_release", obs_rdy, 1);
    check("add_rs1", rs1_o, 1);
    check("add_rs2", rs2_o, 1);
    check("add_rd", rd_o, 2);
    check("add_imm", imm_o, 0);

    // B, U, J immediates.
    cycle(32'hFE000CE3, 32'h8000_000C, 1, 1, 0, 0, 0);
    check("beq_imm", imm_o, 32'hFFFF_FFF8);
    check("beq_rd", rd_o, 0);
    check("beq_wen", wen_o, 0);
    cycle(32'h123450B7, 32'h8000_0010, 1, 1, 0, 0, 0);
    check("lui_imm", imm_o, 32'h1234_5000);
    cycle(32'h008000EF, 32'h8000_0014, 1, 1, 0, 1, 5'd1);
    check("jal_waw", obs_rdy, 0);
    cycle(32'h008000EF, 32'h8000_0014, 1, 1, 0, 0, 0);
    check("jal_imm", imm_o, 32'h8);

    // Backpressure, then back-to-back load on release.
    cycle(32'h00700193, 32'h8000_0018, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h00900213, 32'h8000_001C, 1, 0, 0, 0, 0);
      check("stall_ready", obs_rdy, 0);
      check("stall_valid", valid_o, 1);
      check("stall_pc", pc_o, 32'h8000_0018);
      check("stall_imm", imm_o, 32'h7);
    end
    cycle(32'h00900213, 32'h8000_001C, 1, 1, 0, 0, 0);
    check("b2b_pc", pc_o, 32'h8000_001C);
    check("b2b_imm", imm_o, 32'h9);

    // Flush while stalled drops the packet and refuses the input.
    cycle(32'h00000333, 32'h8000_0020, 1, 0, 1, 0, 0);
    check("flush_ready", obs_rdy, 0);
    check("flush_valid", valid_o, 0);
    cycle(32'h00000333, 32'h8000_0020, 1, 1, 0, 0, 0);
    check("after_flush_pc", pc_o, 32'h8000_0020);

    // Illegal opcode issues without setting busy.
    cycle(32'h0000028F, 32'h8000_0024, 1, 1, 0, 0, 0);
    check("fence_illegal", illegal_o, 1);
    check("fence_wen", wen_o, 0);
    cycle(32'h00100293, 32'h8000_0028, 1, 1, 0, 0, 0);
    check("after_illegal_ready", obs_rdy, 1);

    // Reset mid-stall with x1 busy.
    cycle(32'h000003B3, 32'h8000_002C, 1, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", valid_o, 0);
    check("rst_pc", pc_o, 0);
    check_outputs();
    prev_valid = 1'b0;
    wb_valid_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(32'h00108133, 32'h8000_0030, 1, 1, 0, 0, 0);
    check("rst_busy_cleared", obs_rdy, 1);

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      rinst        = $urandom;
      rinst[6:0]   = ops[$urandom_range(0, 8)];
      rinst[11:7]  = 5'($urandom_range(0, 3));
      rinst[19:15] = 5'($urandom_range(0, 3));
      rinst[24:20] = 5'($urandom_range(0, 3));
      r   = 5'($urandom_range(1, 3));
      rwb = m_busy[r] && ($urandom_range(0, 1) == 1);
      cycle(rinst, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), rwb, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
